// File: rtl/multi_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pwm_pkg
//  Description : Shared widths, constants and scheduler state encoding for the
//                multi-channel closed-loop angle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_pwm_pkg;

    localparam int              ANGLE_W   = 12;
    localparam int              RATIO_W   = 8;
    localparam logic [11:0]     HALF_TURN = 12'd2048;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_CALC   = 3'd2,
        S_PWM    = 3'd3,
        S_FINISH = 3'd4,
        S_FAULT  = 3'd5,
        S_NEXT   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/angle_err_calc.sv
`default_nettype none
// ============================================================================
//  Module      : angle_err_calc
//  Description : Combinational shortest-path angle error and clamped
//                proportional drive ratio.
//                i_target / i_reading : raw 12-bit angles (0..4095)
//                o_err                : |shortest-path error| (0..2048)
//                o_dir                : 1 = drive towards increasing angle
//                o_ratio              : (err >> GAIN_SHIFT) saturated to 8 bits,
//                                       then clamped to [MIN_RATIO, MAX_RATIO]
//  Revision    : 1.0 - initial release
// ============================================================================
module angle_err_calc
    import multi_pwm_pkg::*;
#(
    parameter int                 GAIN_SHIFT = 3,
    parameter logic [RATIO_W-1:0] MIN_RATIO  = 8'd20,
    parameter logic [RATIO_W-1:0] MAX_RATIO  = 8'd200
) (
    input  logic [ANGLE_W-1:0] i_target,
    input  logic [ANGLE_W-1:0] i_reading,
    output logic [ANGLE_W-1:0] o_err,
    output logic               o_dir,
    output logic [RATIO_W-1:0] o_ratio
);

    logic [ANGLE_W-1:0] w_diff;
    logic [ANGLE_W-1:0] w_shift;
    logic [RATIO_W-1:0] w_sat;

    // Modulo-4096 difference falls out of the natural 12-bit wrap.
    assign w_diff = i_target - i_reading;

    always_comb begin
        o_err   = '0;
        o_dir   = 1'b0;
        w_shift = '0;
        w_sat   = '0;
        o_ratio = '0;

        // Exactly half a turn away is treated as a decreasing move.
        if (w_diff < HALF_TURN) begin
            o_err = w_diff;
            o_dir = 1'b1;
        end else begin
            o_err = ANGLE_W'(12'd0 - w_diff);
            o_dir = 1'b0;
        end

        w_shift = o_err >> GAIN_SHIFT;
        // Saturate to 8 bits before the range clamp so large errors do not
        // alias into small ratios.
        w_sat = (|w_shift[ANGLE_W-1:RATIO_W]) ? {RATIO_W{1'b1}} : w_shift[RATIO_W-1:0];

        if (w_sat < MIN_RATIO)
            o_ratio = MIN_RATIO;
        else if (w_sat > MAX_RATIO)
            o_ratio = MAX_RATIO;
        else
            o_ratio = w_sat;
    end

endmodule
`default_nettype wire

// File: rtl/multi_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pwm_ctrl
//  Description : N-channel closed-loop angle controller. A round-robin
//                scheduler reads each busy channel's angle sensor, computes
//                the shortest-path error and issues a clamped proportional
//                PWM ratio plus direction to that channel's PWM generator.
//  Ports       : clock/reset          - clock, synchronous active-high reset
//                target_angle/angle_update - per-channel target and start pulse
//                angle_done/angle_fault    - per-channel completion pulses
//                current_angle/busy        - per-channel status
//                rd_req/rd_ch/rd_ack/rd_data/rd_err - shared sensor read port
//                pwm_enable/pwm_ratio/pwm_direction/pwm_update/pwm_done
//                                          - per-channel PWM generator port
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_pwm_ctrl
    import multi_pwm_pkg::*;
#(
    parameter int                 NUM_CH        = 4,
    parameter int                 GAIN_SHIFT    = 3,
    parameter logic [RATIO_W-1:0] MIN_RATIO     = 8'd20,
    parameter logic [RATIO_W-1:0] MAX_RATIO     = 8'd200,
    parameter logic [ANGLE_W-1:0] TOLERANCE     = 12'd8,
    parameter int                 SETTLE_CNT    = 3,
    parameter int                 TIMEOUT_POLLS = 255,
    localparam int                CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CH*ANGLE_W-1:0]   target_angle,
    input  logic [NUM_CH-1:0]           angle_update,
    output logic [NUM_CH-1:0]           angle_done,
    output logic [NUM_CH-1:0]           angle_fault,
    output logic [NUM_CH*ANGLE_W-1:0]   current_angle,
    output logic [NUM_CH-1:0]           busy,
    output logic                        rd_req,
    output logic [CH_W-1:0]             rd_ch,
    input  logic                        rd_ack,
    input  logic [ANGLE_W-1:0]          rd_data,
    input  logic                        rd_err,
    output logic [NUM_CH-1:0]           pwm_enable,
    output logic [NUM_CH*RATIO_W-1:0]   pwm_ratio,
    output logic [NUM_CH-1:0]           pwm_direction,
    output logic [NUM_CH-1:0]           pwm_update,
    input  logic [NUM_CH-1:0]           pwm_done
);

    // ------------------------------------------------------------------
    // Per-channel and scheduler state
    // ------------------------------------------------------------------
    logic [ANGLE_W-1:0] r_target [NUM_CH];
    logic [ANGLE_W-1:0] r_cur    [NUM_CH];
    logic [RATIO_W-1:0] r_ratio  [NUM_CH];
    logic [7:0]         r_settle [NUM_CH];
    logic [7:0]         r_poll   [NUM_CH];
    logic [NUM_CH-1:0]  r_busy;
    logic [NUM_CH-1:0]  r_done;
    logic [NUM_CH-1:0]  r_fault;
    logic [NUM_CH-1:0]  r_en;
    logic [NUM_CH-1:0]  r_dir;
    logic [NUM_CH-1:0]  r_upd;

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [CH_W-1:0]    r_ptr;
    logic               r_rd_req;
    logic [ANGLE_W-1:0] r_reading;

    logic [CH_W-1:0]    w_next_ch;
    logic [ANGLE_W-1:0] w_err;
    logic               w_dir;
    logic [RATIO_W-1:0] w_ratio;
    logic               w_on_target;
    logic [7:0]         w_poll_nxt;
    logic [7:0]         w_settle_nxt;
    logic               w_settled;
    logic               w_timeout;

    // First busy channel at or after the round-robin pointer. The loop runs
    // from the farthest candidate down so the nearest one is assigned last.
    always_comb begin
        w_next_ch = r_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (r_busy[idx])
                w_next_ch = CH_W'(idx);
        end
    end

    // Single shared error calculator; the target is read at calc time so a
    // retarget during a transaction is honoured by that transaction.
    angle_err_calc #(
        .GAIN_SHIFT (GAIN_SHIFT),
        .MIN_RATIO  (MIN_RATIO),
        .MAX_RATIO  (MAX_RATIO)
    ) u_err_calc (
        .i_target  (r_target[r_ch]),
        .i_reading (r_reading),
        .o_err     (w_err),
        .o_dir     (w_dir),
        .o_ratio   (w_ratio)
    );

    assign w_on_target  = (w_err <= TOLERANCE);
    assign w_poll_nxt   = r_poll[r_ch] + 8'd1;
    assign w_settle_nxt = w_on_target ? (r_settle[r_ch] + 8'd1) : 8'd0;
    assign w_settled    = w_on_target && (w_settle_nxt == 8'(SETTLE_CNT));
    assign w_timeout    = (w_poll_nxt == 8'(TIMEOUT_POLLS));

    // ------------------------------------------------------------------
    // Scheduler FSM and per-channel registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_ptr     <= '0;
            r_rd_req  <= 1'b0;
            r_reading <= '0;
            r_busy    <= '0;
            r_done    <= '0;
            r_fault   <= '0;
            r_en      <= '0;
            r_dir     <= '0;
            r_upd     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= '0;
                r_cur[i]    <= '0;
                r_ratio[i]  <= '0;
                r_settle[i] <= '0;
                r_poll[i]   <= '0;
            end
        end else begin
            r_done  <= '0;
            r_fault <= '0;

            case (r_state)
                S_IDLE: begin
                    if (|r_busy) begin
                        r_ch     <= w_next_ch;
                        r_rd_req <= 1'b1;
                        r_state  <= S_READ;
                    end
                end

                S_READ: begin
                    if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        if (rd_err) begin
                            r_fault[r_ch] <= 1'b1;
                            r_busy[r_ch]  <= 1'b0;
                            r_en[r_ch]    <= 1'b0;
                            r_state       <= S_FAULT;
                        end else begin
                            r_reading   <= rd_data;
                            r_cur[r_ch] <= rd_data;
                            r_state     <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_poll[r_ch]   <= w_poll_nxt;
                    r_settle[r_ch] <= w_settle_nxt;
                    if (w_settled) begin
                        r_done[r_ch] <= 1'b1;
                        r_busy[r_ch] <= 1'b0;
                        r_en[r_ch]   <= 1'b0;
                        r_state      <= S_FINISH;
                    end else if (w_timeout) begin
                        r_fault[r_ch] <= 1'b1;
                        r_busy[r_ch]  <= 1'b0;
                        r_en[r_ch]    <= 1'b0;
                        r_state       <= S_FAULT;
                    end else begin
                        // On-target reads still go through the PWM handshake,
                        // commanding zero drive while settling is counted.
                        r_ratio[r_ch] <= w_on_target ? '0 : w_ratio;
                        r_dir[r_ch]   <= w_dir;
                        r_en[r_ch]    <= 1'b1;
                        r_upd[r_ch]   <= 1'b1;
                        r_state       <= S_PWM;
                    end
                end

                S_PWM: begin
                    if (pwm_done[r_ch]) begin
                        r_upd[r_ch] <= 1'b0;
                        r_state     <= S_NEXT;
                    end
                end

                S_FINISH, S_FAULT: begin
                    r_state <= S_NEXT;
                end

                S_NEXT: begin
                    r_ptr   <= (int'(r_ch) == NUM_CH - 1) ? '0 : r_ch + CH_W'(1);
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Host updates come last so they override any scheduler write to
            // the same channel in this cycle (restart always wins).
            for (int i = 0; i < NUM_CH; i++) begin
                if (angle_update[i]) begin
                    r_target[i] <= target_angle[i*ANGLE_W +: ANGLE_W];
                    r_busy[i]   <= 1'b1;
                    r_settle[i] <= '0;
                    r_poll[i]   <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign angle_done    = r_done;
    assign angle_fault   = r_fault;
    assign busy          = r_busy;
    assign rd_req        = r_rd_req;
    assign rd_ch         = r_ch;
    assign pwm_enable    = r_en;
    assign pwm_direction = r_dir;
    assign pwm_update    = r_upd;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign current_angle[g*ANGLE_W +: ANGLE_W] = r_cur[g];
        assign pwm_ratio[g*RATIO_W +: RATIO_W]     = r_ratio[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_pwm_ctrl
//  Description : Directed self-checking bench for multi_pwm_ctrl: a table of
//                single-read error/ratio vectors plus hand-written sequences
//                for settling, round-robin, sensor error, timeout and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pwm_ctrl;

    localparam int NCH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*12-1:0] target_angle = '0;
    logic [NCH-1:0]    angle_update = '0;
    logic [NCH-1:0]    angle_done;
    logic [NCH-1:0]    angle_fault;
    logic [NCH*12-1:0] current_angle;
    logic [NCH-1:0]    busy;
    logic              rd_req;
    logic [1:0]        rd_ch;
    logic              rd_ack = 1'b0;
    logic [11:0]       rd_data = '0;
    logic              rd_err = 1'b0;
    logic [NCH-1:0]    pwm_enable;
    logic [NCH*8-1:0]  pwm_ratio;
    logic [NCH-1:0]    pwm_direction;
    logic [NCH-1:0]    pwm_update;
    logic [NCH-1:0]    pwm_done = '0;

    int n_vec  = 0;
    int n_miss = 0;

    multi_pwm_ctrl #(.NUM_CH(NCH)) dut (
        .clock         (clock),
        .reset         (reset),
        .target_angle  (target_angle),
        .angle_update  (angle_update),
        .angle_done    (angle_done),
        .angle_fault   (angle_fault),
        .current_angle (current_angle),
        .busy          (busy),
        .rd_req        (rd_req),
        .rd_ch         (rd_ch),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .pwm_enable    (pwm_enable),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .pwm_update    (pwm_update),
        .pwm_done      (pwm_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int target;
        int reading;
        int ratio;
        int dir;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        angle_update = '0;
        rd_ack       = 1'b0;
        rd_err       = 1'b0;
        pwm_done     = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic update_ch(input int ch, input int tgt);
        target_angle[ch*12 +: 12] = 12'(tgt);
        angle_update              = '0;
        angle_update[ch]          = 1'b1;
        @(negedge clock);
        angle_update = '0;
    endtask

    task automatic serve_read(input int ch, input int data, input logic err);
        int k = 0;
        while (!rd_req && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("rd_req seen", 32'(rd_req), 1);
        check($sformatf("rd_ch for ch%0d", ch), 32'(rd_ch), 32'(ch));
        rd_ack  = 1'b1;
        rd_data = 12'(data);
        rd_err  = err;
        @(negedge clock);
        rd_ack = 1'b0;
        rd_err = 1'b0;
        check("rd_req dropped after ack", 32'(rd_req), 0);
    endtask

    task automatic serve_pwm(input int ch, input int ratio, input int dir);
        int k = 0;
        while (!pwm_update[ch] && k < 20) begin
            @(negedge clock);
            k++;
        end
        check($sformatf("pwm_update ch%0d", ch), 32'(pwm_update[ch]), 1);
        check($sformatf("pwm_ratio ch%0d", ch), 32'(pwm_ratio[ch*8 +: 8]), 32'(ratio));
        check($sformatf("pwm_direction ch%0d", ch), 32'(pwm_direction[ch]), 32'(dir));
        check($sformatf("pwm_enable ch%0d", ch), 32'(pwm_enable[ch]), 1);
        // A done on some other channel must not release this handshake.
        pwm_done = '0;
        pwm_done[(ch + 1) % NCH] = 1'b1;
        @(negedge clock);
        check($sformatf("pwm_update held ch%0d", ch), 32'(pwm_update[ch]), 1);
        pwm_done     = '0;
        pwm_done[ch] = 1'b1;
        @(negedge clock);
        pwm_done = '0;
        check($sformatf("pwm_update released ch%0d", ch), 32'(pwm_update[ch]), 0);
    endtask

    // which: 0 = angle_done, 1 = angle_fault
    task automatic wait_pulse(input string nm, input int which, input int ch);
        int   k = 0;
        logic seen = 1'b0;
        while (k < 20) begin
            if ((which == 0) ? angle_done[ch] : angle_fault[ch]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
            k++;
        end
        check({nm, " pulse"}, 32'(seen), 1);
        if (seen) begin
            check({nm, " busy cleared"}, 32'(busy[ch]), 0);
            check({nm, " enable cleared"}, 32'(pwm_enable[ch]), 0);
            @(negedge clock);
            check({nm, " single cycle"},
                  32'((which == 0) ? angle_done[ch] : angle_fault[ch]), 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            ch target reading ratio dir
        vecs[0]  = '{0, 1000,  900,  20, 1};   // err 100 -> 12 -> MIN
        vecs[1]  = '{1,   10, 4000,  20, 1};   // wrap, err 106
        vecs[2]  = '{1, 4000,   10,  20, 0};   // wrap, err 106 other way
        vecs[3]  = '{2, 2000,    0, 200, 1};   // err 2000 -> 250 -> MAX
        vecs[4]  = '{3,    0, 2048, 200, 0};   // half turn: dir 0, 256 sat
        vecs[5]  = '{0,    0, 2047, 200, 0};   // diff 2049 -> err 2047
        vecs[6]  = '{2,  500,  100,  50, 1};   // err 400 -> 50
        vecs[7]  = '{3,  100,  500,  50, 0};   // err 400 reversed
        vecs[8]  = '{0, 1000,  992,   0, 1};   // err 8: on target, zero drive
        vecs[9]  = '{0, 1000,  991,  20, 1};   // err 9: just off target
        vecs[10] = '{1, 3000, 1800, 150, 1};   // err 1200 -> 150
        vecs[11] = '{0,    0,    0,   0, 1};   // zero error

        @(negedge clock);
        apply_reset();
        check("reset busy", 32'(busy), 0);
        check("reset rd_req", 32'(rd_req), 0);
        check("reset rd_ch", 32'(rd_ch), 0);
        check("reset pwm_enable", 32'(pwm_enable), 0);
        check("reset pwm_update", 32'(pwm_update), 0);
        check("reset pwm_ratio", pwm_ratio, 0);
        check("reset current_angle", current_angle[31:0], 0);
        check("reset done/fault", 32'({angle_done, angle_fault}), 0);

        // ---- table-driven single-read vectors ----
        for (int i = 0; i < 12; i++) begin
            apply_reset();
            update_ch(vecs[i].ch, vecs[i].target);
            check($sformatf("vec%0d busy set", i), 32'(busy[vecs[i].ch]), 1);
            check($sformatf("vec%0d rd_req not yet", i), 32'(rd_req), 0);
            @(negedge clock);
            check($sformatf("vec%0d rd_req latency", i), 32'(rd_req), 1);
            serve_read(vecs[i].ch, vecs[i].reading, 1'b0);
            check($sformatf("vec%0d current_angle", i),
                  32'(current_angle[vecs[i].ch*12 +: 12]), 32'(vecs[i].reading));
            serve_pwm(vecs[i].ch, vecs[i].ratio, vecs[i].dir);
        end

        // ---- settle: three on-target reads -> done on the third ----
        apply_reset();
        update_ch(0, 1000);
        serve_read(0, 1000, 1'b0);
        serve_pwm(0, 0, 1);
        serve_read(0, 1000, 1'b0);
        serve_pwm(0, 0, 1);
        check("settle no early done", 32'(angle_done), 0);
        serve_read(0, 1000, 1'b0);
        wait_pulse("settle done", 0, 0);
        check("settle no pwm_update", 32'(pwm_update), 0);

        // ---- round robin across all channels ----
        apply_reset();
        for (int c = 0; c < NCH; c++)
            target_angle[c*12 +: 12] = 12'd1000;
        angle_update = '1;
        @(negedge clock);
        angle_update = '0;
        for (int p = 0; p < 5; p++) begin
            serve_read(p % NCH, 0, 1'b0);
            serve_pwm(p % NCH, 125, 1);
        end

        // ---- sensor error on ch2 ----
        apply_reset();
        for (int c = 0; c < NCH; c++)
            target_angle[c*12 +: 12] = 12'd1000;
        angle_update = '1;
        @(negedge clock);
        angle_update = '0;
        serve_read(0, 0, 1'b0);   serve_pwm(0, 125, 1);
        serve_read(1, 0, 1'b0);   serve_pwm(1, 125, 1);
        serve_read(2, 300, 1'b0); serve_pwm(2, 87, 1);
        serve_read(3, 0, 1'b0);   serve_pwm(3, 125, 1);
        serve_read(0, 0, 1'b0);   serve_pwm(0, 125, 1);
        serve_read(1, 0, 1'b0);   serve_pwm(1, 125, 1);
        serve_read(2, 777, 1'b1);
        wait_pulse("rd_err fault", 1, 2);
        check("rd_err current_angle kept", 32'(current_angle[2*12 +: 12]), 300);
        check("rd_err other busy", 32'(busy), 32'(4'b1011));
        serve_read(3, 0, 1'b0);   serve_pwm(3, 125, 1);
        serve_read(0, 0, 1'b0);   serve_pwm(0, 125, 1);
        serve_read(1, 0, 1'b0);   serve_pwm(1, 125, 1);
        serve_read(3, 0, 1'b0);   serve_pwm(3, 125, 1);

        // ---- timeout after TIMEOUT_POLLS good off-target reads ----
        apply_reset();
        update_ch(0, 1000);
        for (int p = 0; p < 254; p++) begin
            serve_read(0, 0, 1'b0);
            serve_pwm(0, 125, 1);
        end
        serve_read(0, 0, 1'b0);
        wait_pulse("timeout fault", 1, 0);
        check("timeout no done", 32'(angle_done), 0);

        // ---- reset in the middle of a read ----
        apply_reset();
        update_ch(1, 3000);
        begin
            int k = 0;
            while (!rd_req && k < 50) begin
                @(negedge clock);
                k++;
            end
        end
        check("midread rd_req high", 32'(rd_req), 1);
        reset = 1'b1;
        @(negedge clock);
        check("midread rd_req cleared", 32'(rd_req), 0);
        check("midread busy cleared", 32'(busy), 0);
        check("midread rd_ch cleared", 32'(rd_ch), 0);
        reset   = 1'b0;
        rd_ack  = 1'b1;
        rd_data = 12'd1234;
        @(negedge clock);
        rd_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("late ack ignored angle", 32'(current_angle[1*12 +: 12]), 0);
        check("late ack ignored rd_req", 32'(rd_req), 0);
        check("late ack ignored pwm_update", 32'(pwm_update), 0);
        update_ch(1, 3000);
        serve_read(1, 1000, 1'b0);
        serve_pwm(1, 200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
